// File: rtl/result_matrix_collector.sv
// result_matrix_collector
//   Collects the m*m elements of a result matrix, which arrive in any order
//   as indexed strobes. Once every entry has been written at least once, it
//   drains them in row-major order through a valid/ready stream. It then
//   re-arms for the next matrix.
//
//   Optional feature macro: RESULT_COLLECTOR_ERR_EN
//     defined   -> err is a sticky flag. It sets on a duplicate write, on a
//                  strobe arriving while draining, or on an out-of-range index.
//     undefined -> err is tied to 0.
//
//   Ports
//     clk        sole clock, rising edge
//     rst        synchronous active-high reset
//     z_in       32-bit result element (opaque)
//     z_i, z_j   row / column index of z_in
//     z_stb      one-cycle strobe qualifying z_in/z_i/z_j
//     out_data   drained element (0 when not draining)
//     out_valid  out_data valid
//     out_ready  downstream accept
//     out_last   valid on element (m-1,m-1)
//     full       high while draining
//     err        sticky protocol error flag (see macro above)
module result_matrix_collector #(
  parameter int m = 4,
  localparam int W = (m > 1) ? $clog2(m) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   z_in,
  input  logic [W-1:0]  z_i,
  input  logic [W-1:0]  z_j,
  input  logic          z_stb,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          full,
  output logic          err
);

  localparam int N  = m * m;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t         state, state_nx;
  logic [31:0]    mem [N];
  logic [N-1:0]   written;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  rd_idx;

  logic           in_range;
  logic [IW-1:0]  wr_idx;
  logic           wr_en;
  logic           wr_new;
  logic           xfer;
  logic           xfer_last;

  always_comb begin
    in_range  = ({1'b0, z_i} < (W+1)'(m)) && ({1'b0, z_j} < (W+1)'(m));
    wr_idx    = IW'(z_i) * IW'(m) + IW'(z_j);
    wr_en     = (state == COLLECT) && z_stb && in_range;
    wr_new    = wr_en && !written[wr_idx];

    out_valid = (state == DRAIN);
    full      = (state == DRAIN);
    out_last  = out_valid && (rd_idx == IW'(N - 1));
    out_data  = out_valid ? mem[rd_idx] : '0;

    xfer      = out_valid && out_ready;
    xfer_last = xfer && out_last;

    state_nx  = state;
    case (state)
      // The transition happens on the edge that captures the final distinct
      // entry, so out_valid is high in the very next cycle.
      COLLECT: if (wr_new && (cnt == CW'(N - 1))) state_nx = DRAIN;
      DRAIN:   if (xfer_last)                     state_nx = COLLECT;
      default:                                    state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= COLLECT;
      cnt     <= '0;
      written <= '0;
      rd_idx  <= '0;
    end else begin
      state <= state_nx;
      if (wr_new) begin
        written[wr_idx] <= 1'b1;
        cnt             <= cnt + 1'b1;
      end
      if (xfer) begin
        if (xfer_last) begin
          rd_idx  <= '0;
          written <= '0;
          cnt     <= '0;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

  // The data array has no reset; a fresh matrix always rewrites every entry
  // before the array is read again.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_idx] <= z_in;
  end

`ifdef RESULT_COLLECTOR_ERR_EN
  logic err_q;
  logic err_set;

  always_comb begin
    err_set = z_stb && ((state == DRAIN) || !in_range || written[wr_idx]);
  end

  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_result_matrix_collector.sv
module tb_result_matrix_collector;

  localparam int M = 4;
  localparam int N = M * M;
`ifdef RESULT_COLLECTOR_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] z_in = '0;
  logic [1:0]  z_i = '0;
  logic [1:0]  z_j = '0;
  logic        z_stb = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        full;
  logic        err;

  int tests = 0;
  int fails = 0;

  // Reference model: the matrix contents, which entries have been seen,
  // whether the matrix is complete (draining), and the drain position.
  logic [31:0] ref_mem [N];
  bit          ref_seen [N];
  int          ref_cnt;
  bit          ref_drain;
  int          ref_rd;
  bit          ref_err;

  result_matrix_collector #(.m(M)) dut (
    .clk(clk), .rst(rst), .z_in(z_in), .z_i(z_i), .z_j(z_j), .z_stb(z_stb),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) ref_seen[k] = 1'b0;
    ref_cnt   = 0;
    ref_drain = 1'b0;
    ref_rd    = 0;
  endtask

  task automatic model_strobe(input int i, input int j, input logic [31:0] v);
    int k;
    k = i * M + j;
    if (ref_drain) begin
      ref_err = 1'b1;
    end else begin
      if (ref_seen[k]) ref_err = 1'b1;
      else begin
        ref_seen[k] = 1'b1;
        ref_cnt++;
      end
      ref_mem[k] = v;
      if (ref_cnt == N) ref_drain = 1'b1;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ref_drain});
    check({tag, ".full"},  {31'd0, full},      {31'd0, ref_drain});
    check({tag, ".err"},   {31'd0, err},       {31'd0, ERR_ON & ref_err});
  endtask

  task automatic do_write(input int i, input int j, input logic [31:0] v);
    z_i   = 2'(i);
    z_j   = 2'(j);
    z_in  = v;
    z_stb = 1'b1;
    tick();
    z_stb = 1'b0;
    model_strobe(i, j, v);
    check("wr.valid", {31'd0, out_valid}, {31'd0, ref_drain});
  endtask

  // Writes all entries once, in row-major or shuffled order.
  task automatic fill(input bit scramble, input bit rand_data);
    int order [N];
    int t, r;
    for (int k = 0; k < N; k++) order[k] = k;
    if (scramble)
      for (int k = N - 1; k > 0; k--) begin
        r = int'($urandom_range(k, 0));
        t = order[k]; order[k] = order[r]; order[r] = t;
      end
    for (int k = 0; k < N; k++)
      do_write(order[k] / M, order[k] % M,
               rand_data ? $urandom : 32'(order[k]));
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
  // Stops after 'limit' transfers or when the model leaves drain.
  task automatic drain(input int mode, input bit strobes, input int limit);
    int  xfers;
    int  cyc;
    bit  rdy;
    bit  stb;
    xfers = 0;
    cyc   = 0;
    while (ref_drain && xfers < limit && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(1, 0));
      endcase
      stb       = strobes && ($urandom_range(2, 0) == 0);
      out_ready = rdy;
      z_stb     = stb;
      z_i       = 2'($urandom_range(3, 0));
      z_j       = 2'($urandom_range(3, 0));
      z_in      = $urandom;
      #1;
      check("dr.valid", {31'd0, out_valid}, 32'd1);
      check("dr.data",  out_data, ref_mem[ref_rd]);
      check("dr.last",  {31'd0, out_last}, {31'd0, (ref_rd == N - 1)});
      tick();
      z_stb = 1'b0;
      if (stb) ref_err = 1'b1;
      if (rdy) begin
        xfers++;
        ref_rd++;
        if (ref_rd == N) model_clear();
      end
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= 400) check("dr.timeout", 32'd1, 32'd0);
    check_status("dr.end");
  endtask

  initial begin
    ref_err = 1'b0;
    model_clear();

    // Reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.data", out_data, 32'd0);
    check("rst.last", {31'd0, out_last}, 32'd0);
    check_status("rst");

    // Row-major fill with value = index, drain at full rate
    fill(1'b0, 1'b0);
    drain(0, 1'b0, N);

    // Scrambled fill with value = index
    fill(1'b1, 1'b0);
    drain(0, 1'b0, N);

    // Scrambled fill with random data, random backpressure
    fill(1'b1, 1'b1);
    drain(2, 1'b0, N);

    // Duplicate write to (1,2): 17 strobes, last value wins
    for (int k = 0; k < N; k++) begin
      do_write(k / M, k % M, (k == 6) ? 32'hAAAA0000 : $urandom);
      if (k == 10) begin
        do_write(1, 2, 32'h5555FFFF);
        check_status("dup");
      end
    end
    check("dup.e6", ref_mem[6], 32'h5555FFFF);
    drain(0, 1'b0, N);

    // Stall pattern with strobes dropped during drain
    fill(1'b1, 1'b1);
    drain(1, 1'b1, N);

    // Reset mid-drain, with a concurrent strobe, then a fresh matrix
    fill(1'b1, 1'b1);
    drain(0, 1'b0, 5);
    rst       = 1'b1;
    out_ready = 1'b1;
    z_stb     = 1'b1;
    z_i       = 2'd0;
    z_j       = 2'd0;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    z_stb     = 1'b0;
    ref_err   = 1'b0;
    model_clear();
    check("rst2.data", out_data, 32'd0);
    check_status("rst2");
    fill(1'b1, 1'b1);
    drain(2, 1'b0, N);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
